// File: rtl/cache_structs_def.sv
// Shared cache/memory types: block layout, memory handshake bundles
// and the miss engine state encoding.
package cache_structs_def;

   localparam int ADDR_WIDTH   = 16;
   localparam int DATA_WIDTH   = 32;
   localparam int BLOCK_SIZE   = 4;
   localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE);

   typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;

   typedef struct packed {
      logic                  cs;
      logic                  rw;
      logic [ADDR_WIDTH-1:0] addr;
      block_t                data;
   } memory_request_t;

   typedef struct packed {
      logic   ack;
      block_t data;
   } memory_response_t;

   typedef enum logic [2:0] {
      IDLE,
      WB,
      GAP,
      FILL,
      DONE
   } miss_state_t;

   // Memory adds the word offset itself, so requests carry block bases.
   function automatic logic [ADDR_WIDTH-1:0] block_align(
      input logic [ADDR_WIDTH-1:0] a
   );
      return a & ~ADDR_WIDTH'(BLOCK_SIZE - 1);
   endfunction

endpackage

// File: rtl/cache_miss_engine_ack_watchdog.sv
// Clear/enable wait counter that flags the last cycle a memory
// operation may still be acknowledged before it is abandoned.
module ack_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CW =
      (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST  =
      CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   logic [CW-1:0] cnt_q, cnt_d;

   // Count waiting cycles, saturating at the limit instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Fires in the last allowed waiting cycle; zero limit disables it.
   assign expired_o = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q >= LAST);

endmodule

// File: rtl/cache_miss_engine.sv
// Cache miss initiator: optional dirty write-back, then block refill,
// over the shared memory request/response handshake.
module cache_miss_engine
   import cache_structs_def::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  miss_valid,
   output logic                  miss_ready,
   input  logic [ADDR_WIDTH-1:0] miss_addr,
   input  logic                  miss_dirty,
   input  logic [ADDR_WIDTH-1:0] victim_addr,
   input  block_t                victim_data,
   output memory_request_t       mem_req,
   input  memory_response_t      mem_res,
   output logic                  fill_valid,
   output logic [ADDR_WIDTH-1:0] fill_addr,
   output block_t                fill_data,
   output logic                  err
);

   miss_state_t           state_q, state_d;
   memory_request_t       req_q, req_d;
   logic                  ready_q, ready_d;
   logic                  fvalid_q, fvalid_d;
   logic                  err_q, err_d;
   logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
   block_t                fdata_q, fdata_d;
   logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
   logic                  wd_clr, wd_en, wd_expired;

   ack_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wd (
      .clk_i    (clk),
      .rst_ni   (rst),
      .clr_i    (wd_clr),
      .en_i     (wd_en),
      .expired_o(wd_expired)
   );

   // Next state and next registered outputs; the request is built one
   // cycle ahead so cs/addr/rw/data come straight from flops.
   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      ready_d  = ready_q;
      fvalid_d = 1'b0;
      err_d    = 1'b0;
      faddr_d  = faddr_q;
      fdata_d  = fdata_q;
      maddr_d  = maddr_q;
      wd_clr   = 1'b0;
      wd_en    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (miss_valid && ready_q) begin
               maddr_d  = block_align(miss_addr);
               ready_d  = 1'b0;
               wd_clr   = 1'b1;
               req_d.cs = 1'b1;
               req_d.rw = miss_dirty;
               if (miss_dirty) begin
                  state_d    = WB;
                  req_d.addr = block_align(victim_addr);
                  req_d.data = victim_data;
               end else begin
                  state_d    = FILL;
                  req_d.addr = block_align(miss_addr);
                  req_d.data = '0;
               end
            end
         end
         WB: begin
            wd_en = 1'b1;
            if (mem_res.ack) begin
               state_d = GAP;
               req_d   = '0;
            end else if (wd_expired) begin
               state_d = DONE;
               req_d   = '0;
               err_d   = 1'b1;
            end
         end
         GAP: begin
            wd_clr     = 1'b1;
            state_d    = FILL;
            req_d.cs   = 1'b1;
            req_d.rw   = 1'b0;
            req_d.addr = maddr_q;
            req_d.data = '0;
         end
         FILL: begin
            wd_en = 1'b1;
            if (mem_res.ack) begin
               state_d  = DONE;
               req_d    = '0;
               fvalid_d = 1'b1;
               fdata_d  = mem_res.data;
               faddr_d  = maddr_q;
            end else if (wd_expired) begin
               state_d = DONE;
               req_d   = '0;
               err_d   = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            req_d   = '0;
            ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers; reset abandons any operation at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         req_q    <= '0;
         ready_q  <= 1'b1;
         fvalid_q <= 1'b0;
         err_q    <= 1'b0;
         faddr_q  <= '0;
         fdata_q  <= '0;
         maddr_q  <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         ready_q  <= ready_d;
         fvalid_q <= fvalid_d;
         err_q    <= err_d;
         faddr_q  <= faddr_d;
         fdata_q  <= fdata_d;
         maddr_q  <= maddr_d;
      end
   end

   assign miss_ready = ready_q;
   assign mem_req    = req_q;
   assign fill_valid = fvalid_q;
   assign fill_addr  = faddr_q;
   assign fill_data  = fdata_q;
   assign err        = err_q;

endmodule
